// File: rtl/riscv_store_pkg.sv
// Shared types and the store formatting function for the store unit.
// Entry fields are sized for the widest configuration; narrower builds use the low slices.
package riscv_store_pkg;

    localparam int unsigned MAX_XLEN = 64;
    localparam int unsigned MAX_NB   = MAX_XLEN / 8;
    localparam int unsigned MAX_AW   = 64;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

    typedef logic [2*MAX_XLEN-1:0] wide_dat_t;
    typedef logic [2*MAX_NB-1:0]   wide_strb_t;

    typedef struct packed {
        logic [MAX_AW-1:0] addr;
        wide_dat_t         dat;
        wide_strb_t        strb;
        logic              two_beat;
    } store_entry_t;

    // Lowest set enable bit selects the size.
    function automatic size_e size_decode(input logic [3:0] en);
        if (en[0]) return SZ_B;
        if (en[1]) return SZ_H;
        if (en[2]) return SZ_W;
        return SZ_D;
    endfunction

    // Align register data and strobes across two memory words of nb bytes each.
    function automatic store_entry_t store_format(
        input logic [3:0]          en,
        input logic [MAX_AW-1:0]   addr,
        input logic [MAX_XLEN-1:0] dat,
        input int unsigned         nb
    );
        store_entry_t e;
        int unsigned  bytes;
        int unsigned  off;
        bytes      = 32'(1) << size_decode(en);
        off        = 32'(addr[2:0]) & (nb - 1);
        e.addr     = addr & ~MAX_AW'(nb - 1);
        e.dat      = wide_dat_t'(dat) << (8 * off);
        e.strb     = ((wide_strb_t'(1) << bytes) - wide_strb_t'(1)) << off;
        e.two_beat = (e.strb >> nb) != '0;
        return e;
    endfunction

endpackage

// File: rtl/riscv_store_unit_fifo.sv
// Store-buffer FIFO; also exposes the entry behind the head for back-to-back issue.
module riscv_store_fifo
    import riscv_store_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  store_entry_t       din,
    output store_entry_t       dout,
    output store_entry_t       dout_next,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    store_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign dout      = mem_q[rd_ptr];
    assign dout_next = mem_q[ptr_inc(rd_ptr)];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= din;
    end

endmodule

// File: rtl/riscv_store_unit.sv
// Store unit: formats execute-stage stores, buffers them and issues
// one or two registered write beats per store to the data-memory port.
module riscv_store_unit
    import riscv_store_pkg::*;
#(
    parameter  int unsigned RV64       = 0,
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned DEPTH      = 2,
    localparam int unsigned CPU_WIDTH  = 32 * (RV64 + 1),
    localparam int unsigned NB         = CPU_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_vld_i,
    output logic                  st_rdy_o,
    input  logic [2+RV64:0]       store_en_i,
    input  logic [ADDR_WIDTH-1:0] st_addr_i,
    input  logic [CPU_WIDTH-1:0]  st_dat_i,
    output logic                  mem_vld_o,
    input  logic                  mem_rdy_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [CPU_WIDTH-1:0]  mem_dat_o,
    output logic [NB-1:0]         mem_strb_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    store_entry_t          fmt;
    store_entry_t          head;
    store_entry_t          head_next;
    store_entry_t          src;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  hs;
    state_e                state;
    state_e                state_nxt;
    logic                  load;
    logic                  load_next;
    logic                  load_hi;
    logic                  vld_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [CPU_WIDTH-1:0]  dat_nxt;
    logic [NB-1:0]         strb_nxt;
    logic                  unused_bits;

    assign fmt         = store_format(4'(store_en_i), MAX_AW'(st_addr_i), MAX_XLEN'(st_dat_i), NB);
    assign st_rdy_o    = ~full;
    assign push        = st_vld_i & st_rdy_o & (|store_en_i);
    assign busy_o      = ~empty | mem_vld_o;
    assign hs          = mem_vld_o & mem_rdy_i;
    assign unused_bits = ^{head, head_next};

    riscv_store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .din       (fmt),
        .dout      (head),
        .dout_next (head_next),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Next state and the beat to load into the output registers.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_next = 1'b0;
        load_hi   = 1'b0;
        vld_nxt   = mem_vld_o;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = BEAT0;
                    load      = 1'b1;
                end
            end
            BEAT0, BEAT1: begin
                if (hs) begin
                    if (state == BEAT0 && head.two_beat) begin
                        state_nxt = BEAT1;
                        load      = 1'b1;
                        load_hi   = 1'b1;
                    end else begin
                        pop = 1'b1;
                        if (count > CNT_W'(1)) begin
                            state_nxt = BEAT0;
                            load      = 1'b1;
                            load_next = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            vld_nxt   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase

        src      = load_next ? head_next : head;
        addr_nxt = mem_addr_o;
        dat_nxt  = mem_dat_o;
        strb_nxt = mem_strb_o;
        if (load) begin
            vld_nxt  = 1'b1;
            addr_nxt = src.addr[ADDR_WIDTH-1:0] + (load_hi ? ADDR_WIDTH'(NB) : '0);
            dat_nxt  = load_hi ? src.dat[CPU_WIDTH +: CPU_WIDTH] : src.dat[0 +: CPU_WIDTH];
            strb_nxt = load_hi ? src.strb[NB +: NB] : src.strb[0 +: NB];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_vld_o  <= 1'b0;
            mem_addr_o <= '0;
            mem_dat_o  <= '0;
            mem_strb_o <= '0;
        end else begin
            state      <= state_nxt;
            mem_vld_o  <= vld_nxt;
            mem_addr_o <= addr_nxt;
            mem_dat_o  <= dat_nxt;
            mem_strb_o <= strb_nxt;
        end
    end

endmodule
